// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code values, control width and legality check.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'h9;
    localparam logic [ALU_CTRL_W-1:0] ALU_BEQ  = 4'ha;
    localparam logic [ALU_CTRL_W-1:0] ALU_BNE  = 4'hb;
    localparam logic [ALU_CTRL_W-1:0] ALU_BLT  = 4'hc;
    localparam logic [ALU_CTRL_W-1:0] ALU_BGEU = 4'hd;

    // Codes above the last defined op are reserved and flagged as errors.
    function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] ctrl);
        return ctrl <= ALU_BGEU;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Two-requester ALU request/response bundle; slice i of each vector belongs to requester i.
interface alu_share_arb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
);

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic [2*DATA_W-1:0] req_op1;
    logic [2*DATA_W-1:0] req_op2;

    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*DATA_W-1:0] rsp_data;
    logic [1:0]          rsp_zero;
    logic [1:0]          rsp_err;

    modport master (
        output req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the pointer only matters when both requesters are eligible.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       rr_ptr,
    output logic [1:0] grant_c,
    output logic       grant_idx_c
);

    // One-hot grant plus its index for the operand mux.
    always_comb begin
        grant_c     = 2'b00;
        grant_idx_c = 1'b0;
        if (&elig) begin
            grant_idx_c = rr_ptr;
            grant_c     = rr_ptr ? 2'b10 : 2'b01;
        end else if (elig[1]) begin
            grant_idx_c = 1'b1;
            grant_c     = 2'b10;
        end else if (elig[0]) begin
            grant_c     = 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the execute (0) and branch/compare (1) requesters.
// Operands are registered into a single issue stage; results land in per-requester slots.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_arb_if.slave    bus,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [DATA_W-1:0] alu_out
);

    logic              iss_valid;
    logic              iss_owner;
    logic              iss_err;
    logic              rr_ptr;

    logic [1:0]        rsp_valid_q;
    logic [1:0]        busy_c;
    logic [1:0]        elig_c;
    logic [1:0]        grant_c;
    logic              grant_idx_c;

    logic [CTRL_W-1:0] sel_ctrl_c;
    logic [DATA_W-1:0] sel_op1_c;
    logic [DATA_W-1:0] sel_op2_c;
    logic              sel_legal_c;
    logic [DATA_W-1:0] result_c;

    // A requester is busy while its op is in the issue stage or its response is unread.
    always_comb begin
        busy_c = 2'b00;
        for (int i = 0; i < 2; i++) begin
            busy_c[i] = rsp_valid_q[i] | (iss_valid & (iss_owner == 1'(i)));
        end
        elig_c = bus.req_valid & ~busy_c;
    end

    rr_arb2 u_arb (
        .elig        (elig_c),
        .rr_ptr      (rr_ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign bus.req_ready = rst ? 2'b00 : grant_c;

    // Operand mux towards the issue stage, selected by the granted requester.
    always_comb begin
        sel_ctrl_c  = grant_idx_c ? bus.req_ctrl[CTRL_W +: CTRL_W] : bus.req_ctrl[0 +: CTRL_W];
        sel_op1_c   = grant_idx_c ? bus.req_op1[DATA_W +: DATA_W]  : bus.req_op1[0 +: DATA_W];
        sel_op2_c   = grant_idx_c ? bus.req_op2[DATA_W +: DATA_W]  : bus.req_op2[0 +: DATA_W];
        sel_legal_c = alu_ctrl_legal(ALU_CTRL_W'(sel_ctrl_c));
    end

    // Issue stage: capture the granted op; ALU inputs hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_owner <= 1'b0;
            iss_err   <= 1'b0;
            rr_ptr    <= 1'b0;
            alu_ctrl  <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
        end else if (|grant_c) begin
            iss_valid <= 1'b1;
            iss_owner <= grant_idx_c;
            iss_err   <= ~sel_legal_c;
            rr_ptr    <= ~grant_idx_c;
            alu_ctrl  <= sel_legal_c ? sel_ctrl_c : '0;
            alu_op1   <= sel_op1_c;
            alu_op2   <= sel_op2_c;
        end else begin
            iss_valid <= 1'b0;
        end
    end

    // Illegal ops retire as a zero result so the zero flag stays consistent with the data.
    assign result_c = iss_err ? '0 : alu_out;

    assign bus.rsp_valid = rsp_valid_q;

    for (genvar i = 0; i < 2; i++) begin : g_slot
        logic              vld_q;
        logic              zero_q;
        logic              err_q;
        logic [DATA_W-1:0] data_q;
        logic              retire_c;

        assign retire_c = iss_valid & (iss_owner == 1'(i));

        // Response slot: load on retire, clear valid on pop; data is kept after the pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                zero_q <= 1'b0;
                err_q  <= 1'b0;
                data_q <= '0;
            end else if (retire_c) begin
                vld_q  <= 1'b1;
                zero_q <= ~|result_c;
                err_q  <= iss_err;
                data_q <= result_c;
            end else if (vld_q && bus.rsp_ready[i]) begin
                vld_q  <= 1'b0;
            end
        end

        assign rsp_valid_q[i]                  = vld_q;
        assign bus.rsp_zero[i]                 = zero_q;
        assign bus.rsp_err[i]                  = err_q;
        assign bus.rsp_data[i*DATA_W +: DATA_W] = data_q;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural outstanding-op model checked every cycle plus directed literal checks.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_op1;
    logic [DW-1:0] alu_op2;
    logic [DW-1:0] alu_out;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arb_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    alu_share_arb #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_ctrl (alu_ctrl),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_out  (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_BEQ:  return {31'b0, a == b};
            ALU_BNE:  return {31'b0, a != b};
            ALU_BLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_BGEU: return {31'b0, a >= b};
            default:  return 32'h0;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_ctrl, alu_op1, alu_op2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each requester owns at most one op in flight: either being computed or waiting to be read.
    bit          m_init = 0;
    bit          m_pend [2];     // response waiting to be read
    logic [31:0] m_data [2];
    bit          m_zero [2];
    bit          m_err  [2];
    bit          m_fly;          // an op is being computed this cycle
    int          m_fly_port;
    logic [31:0] m_fly_res;
    bit          m_fly_err;
    int          m_last;         // requester to favour on the next tie
    logic [3:0]  m_actrl;
    logic [31:0] m_aop1, m_aop2;
    logic [1:0]  e_gnt;
    int          gi;

    always @(negedge clk) begin
        bit         can [2];
        logic [3:0] c;
        logic [31:0] a, b;
        for (int p = 0; p < 2; p++)
            can[p] = bus.req_valid[p] && !m_pend[p] && !(m_fly && m_fly_port == p);
        if (can[0] && can[1]) gi = m_last;
        else if (can[0])      gi = 0;
        else if (can[1])      gi = 1;
        else                  gi = -1;
        e_gnt = (rst || gi < 0) ? 2'b00 : ((gi == 0) ? 2'b01 : 2'b10);

        if (m_init) begin
            chk("req_ready", 64'(bus.req_ready), 64'(e_gnt));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rsp_valid%0d", p), 64'(bus.rsp_valid[p]), 64'(m_pend[p]));
                chk($sformatf("rsp_data%0d", p), 64'(bus.rsp_data[p*32 +: 32]), 64'(m_data[p]));
                chk($sformatf("rsp_zero%0d", p), 64'(bus.rsp_zero[p]), 64'(m_zero[p]));
                chk($sformatf("rsp_err%0d", p), 64'(bus.rsp_err[p]), 64'(m_err[p]));
            end
            chk("alu_ctrl", 64'(alu_ctrl), 64'(m_actrl));
            chk("alu_op1", 64'(alu_op1), 64'(m_aop1));
            chk("alu_op2", 64'(alu_op2), 64'(m_aop2));
        end

        if (rst) begin
            m_init = 1;
            m_fly  = 0;
            m_last = 0;
            m_actrl = '0; m_aop1 = '0; m_aop2 = '0;
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_data[p] = '0; m_zero[p] = 0; m_err[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (m_pend[p] && bus.rsp_ready[p]) m_pend[p] = 0;
            if (m_fly) begin
                m_pend[m_fly_port] = 1;
                m_data[m_fly_port] = m_fly_res;
                m_zero[m_fly_port] = (m_fly_res == 0);
                m_err[m_fly_port]  = m_fly_err;
            end
            if (gi >= 0) begin
                c = bus.req_ctrl[gi*4 +: 4];
                a = bus.req_op1[gi*32 +: 32];
                b = bus.req_op2[gi*32 +: 32];
                m_fly      = 1;
                m_fly_port = gi;
                m_fly_err  = (c > 4'd13);
                m_fly_res  = m_fly_err ? 32'h0 : alu_fn(c, a, b);
                m_actrl    = m_fly_err ? 4'h0 : c;
                m_aop1     = a;
                m_aop2     = b;
                m_last     = 1 - gi;
            end else begin
                m_fly = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[p]       = 1'b1;
        bus.req_ctrl[p*4 +: 4] = c;
        bus.req_op1[p*32 +: 32] = a;
        bus.req_op2[p*32 +: 32] = b;
    endtask

    // Returns at the falling edge of the cycle in which requester p is granted.
    task automatic wait_gnt(input int p);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[p]) got = 1;
            else nxt();
        end
        chk($sformatf("grant_seen%0d", p), 64'(got), 64'd1);
    endtask

    task automatic drain(input int n);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (n) nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    logic [1:0] exp_seq [6];
    int g0;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_ctrl = '0; bus.req_op1 = '0; bus.req_op2 = '0;
        bus.rsp_ready = '0;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        nxt();
        rst = 1'b0;

        // Single op: ADD 5+7 on port 0
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("single_ready", 64'(bus.req_ready), 64'b01);
        nxt();                       // accept edge
        bus.req_valid = 2'b00;
        nxt();                       // retire edge
        @(negedge clk);
        chk("single_valid", 64'(bus.rsp_valid), 64'b01);
        chk("single_data", 64'(bus.rsp_data[31:0]), 64'd12);
        chk("single_zero", 64'(bus.rsp_zero[0]), 64'd0);
        nxt();
        @(negedge clk);
        chk("single_hold", 64'(bus.rsp_data[31:0]), 64'd12);
        bus.rsp_ready = 2'b01;
        nxt();                       // pop edge
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        chk("single_pop", 64'(bus.rsp_valid), 64'd0);
        nxt();

        // Contention from reset: SUB 9-9 vs XOR 3^5
        rst = 1'b1;
        bus.rsp_ready = 2'b11;
        set_req(0, ALU_SUB, 32'd9, 32'd9);
        set_req(1, ALU_XOR, 32'd3, 32'd5);
        nxt();
        rst = 1'b0;
        exp_seq = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("contend_gnt%0d", k), 64'(bus.req_ready), 64'(exp_seq[k]));
            if (k == 2) begin
                chk("contend_v0", 64'(bus.rsp_valid[0]), 64'd1);
                chk("contend_d0", 64'(bus.rsp_data[31:0]), 64'd0);
                chk("contend_z0", 64'(bus.rsp_zero[0]), 64'd1);
            end
            if (k == 3) begin
                chk("contend_v1", 64'(bus.rsp_valid[1]), 64'd1);
                chk("contend_d1", 64'(bus.rsp_data[63:32]), 64'd6);
                chk("contend_z1", 64'(bus.rsp_zero[1]), 64'd0);
            end
            nxt();
        end
        drain(4);

        // Backpressure: port 1 SLT -1<1 held unread, port 0 keeps issuing
        bus.rsp_ready = 2'b01;
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        wait_gnt(1);
        nxt();                       // accept edge
        nxt();                       // retire edge
        g0 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid1", 64'(bus.rsp_valid[1]), 64'd1);
            chk("bp_data1", 64'(bus.rsp_data[63:32]), 64'd1);
            chk("bp_ready1", 64'(bus.req_ready[1]), 64'd0);
            if (bus.req_ready[0]) g0++;
            nxt();
        end
        chk("bp_port0_progress", 64'(g0 >= 1), 64'd1);
        drain(4);

        // Illegal op 0xf on port 0
        set_req(0, 4'hf, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_gnt(0);
        nxt();
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("ill_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("ill_alu_op1", 64'(alu_op1), 64'hFFFF_FFFF);
        nxt();
        @(negedge clk);
        chk("ill_valid", 64'(bus.rsp_valid[0]), 64'd1);
        chk("ill_data", 64'(bus.rsp_data[31:0]), 64'd0);
        chk("ill_err", 64'(bus.rsp_err[0]), 64'd1);
        chk("ill_zero", 64'(bus.rsp_zero[0]), 64'd1);
        drain(3);

        // Reset while port 1 AND is in flight
        set_req(1, ALU_AND, 32'hF0, 32'h3C);
        wait_gnt(1);
        nxt();                       // accept edge
        rst = 1'b1;
        set_req(0, ALU_ADD, 32'd2, 32'd2);
        @(negedge clk);
        chk("rstmid_ready", 64'(bus.req_ready), 64'd0);
        chk("rstmid_issued_ctrl", 64'(alu_ctrl), 64'(ALU_AND));
        nxt();                       // reset edge
        @(negedge clk);
        chk("rstmid_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rstmid_ready2", 64'(bus.req_ready), 64'd0);
        chk("rstmid_alu_ctrl", 64'(alu_ctrl), 64'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_first_gnt", 64'(bus.req_ready), 64'b01);
        drain(4);

        // Back-to-back on port 0: SLL 1<<4 then SLL 3<<2
        bus.rsp_ready = 2'b11;
        set_req(0, ALU_SLL, 32'd1, 32'd4);
        wait_gnt(0);
        nxt();                       // accept edge
        set_req(0, ALU_SLL, 32'd3, 32'd2);
        @(negedge clk);
        chk("b2b_busy_iss", 64'(bus.req_ready[0]), 64'd0);
        nxt();                       // retire edge
        @(negedge clk);
        chk("b2b_v1", 64'(bus.rsp_valid[0]), 64'd1);
        chk("b2b_d1", 64'(bus.rsp_data[31:0]), 64'd16);
        chk("b2b_busy_rsp", 64'(bus.req_ready[0]), 64'd0);
        nxt();                       // pop edge
        @(negedge clk);
        chk("b2b_popped", 64'(bus.rsp_valid[0]), 64'd0);
        chk("b2b_regrant", 64'(bus.req_ready[0]), 64'd1);
        nxt();                       // second accept
        bus.req_valid = 2'b00;
        nxt();                       // second retire
        @(negedge clk);
        chk("b2b_v2", 64'(bus.rsp_valid[0]), 64'd1);
        chk("b2b_d2", 64'(bus.rsp_data[31:0]), 64'd12);
        nxt();
        @(negedge clk);
        chk("b2b_no_dup", 64'(bus.rsp_valid[0]), 64'd0);
        drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
